// File: rtl/cpu_mdu_arbiter.sv
// Two-requester round-robin front end for the shared multiply/divide unit: one
// operation in flight, result held in a shared buffer until its owner takes it.
module cpu_mdu_arbiter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [2:0]      req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic [2:0]      req1_op,
    input  logic            flush0,
    input  logic            flush1,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic [XLEN-1:0] mdu_operand_a,
    output logic [XLEN-1:0] mdu_operand_b,
    output logic [2:0]      mdu_control,
    output logic            mdu_start,
    input  logic [XLEN-1:0] mdu_result,
    input  logic            mdu_ready,
    output logic            busy,
    output logic [1:0]      state_dbg
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic            rr_q, rr_d;
    logic            owner_q, owner_d;
    logic            discard_q, discard_d;
    logic [XLEN-1:0] opa_q, opa_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [2:0]      ctl_q, ctl_d;
    logic [XLEN-1:0] res_q, res_d;

    logic elig0, elig1, grant1, accept;
    logic owner_flush, owner_rsp_ready;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; ready never waits on anything registered by the requester.
    always_comb begin
        elig0      = req0_valid && !flush0;
        elig1      = req1_valid && !flush1;
        grant1     = elig1 && (!elig0 || rr_q);
        req0_ready = (state_q == S_IDLE) && elig0 && !grant1;
        req1_ready = (state_q == S_IDLE) && grant1;
        accept     = req0_ready || req1_ready;
        owner_flush     = owner_q ? flush1 : flush0;
        owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        discard_d = discard_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        ctl_d     = ctl_q;
        res_d     = res_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    opa_d     = grant1 ? req1_a  : req0_a;
                    opb_d     = grant1 ? req1_b  : req0_b;
                    ctl_d     = grant1 ? req1_op : req0_op;
                    owner_d   = grant1;
                    discard_d = 1'b0;
                    rr_d      = !grant1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (owner_flush) discard_d = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A killed operation still runs to completion; only its result is dropped.
                if (owner_flush) discard_d = 1'b1;
                if (mdu_ready) begin
                    res_d   = mdu_result;
                    state_d = (discard_q || owner_flush) ? S_IDLE : S_RESP;
                end
            end
            S_RESP: begin
                if (owner_rsp_ready || owner_flush) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rr_q      <= 1'b0;
            owner_q   <= 1'b0;
            discard_q <= 1'b0;
            opa_q     <= '0;
            opb_q     <= '0;
            ctl_q     <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            owner_q   <= owner_d;
            discard_q <= discard_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            ctl_q     <= ctl_d;
            res_q     <= res_d;
        end
    end

    // A flush in the response cycle hides the result from its owner immediately.
    assign rsp0_valid    = (state_q == S_RESP) && !owner_q && !flush0;
    assign rsp1_valid    = (state_q == S_RESP) &&  owner_q && !flush1;
    assign rsp_result    = res_q;
    assign mdu_operand_a = opa_q;
    assign mdu_operand_b = opb_q;
    assign mdu_control   = ctl_q;
    assign mdu_start     = (state_q == S_ISSUE);
    assign busy          = (state_q != S_IDLE);
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_cpu_mdu_arbiter.sv
// Bench for cpu_mdu_arbiter: behavioural MDU with fixed latency, directed
// scenarios plus randomized two-requester traffic against a scoreboard.
module tb_cpu_mdu_arbiter;

    localparam int XLEN = 32;
    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

    logic            clk, reset;
    logic            req0_valid, req0_ready, req1_valid, req1_ready;
    logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]      req0_op, req1_op;
    logic            flush0, flush1;
    logic            rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [XLEN-1:0] rsp_result, mdu_operand_a, mdu_operand_b, mdu_result;
    logic [2:0]      mdu_control;
    logic            mdu_start, mdu_ready, busy;
    logic [1:0]      state_dbg;

    int n_checks = 0;
    int n_fail = 0;
    int n_delivered = 0;
    logic [XLEN:0] exp_q[$];
    logic rr_m;

    cpu_mdu_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .flush0(flush0), .flush1(flush1),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .mdu_operand_a(mdu_operand_a), .mdu_operand_b(mdu_operand_b),
        .mdu_control(mdu_control), .mdu_start(mdu_start), .mdu_result(mdu_result), .mdu_ready(mdu_ready),
        .busy(busy), .state_dbg(state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference arithmetic ----------------
    function automatic logic [XLEN-1:0] ref_mdu(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        r  = '0;
        case (op)
            OP_MUL:    begin r = ua * ub;           return r[31:0];  end
            OP_MULH:   begin r = sa * sb;           return r[63:32]; end
            OP_MULHSU: begin r = sa * longint'(ub); return r[63:32]; end
            OP_MULHU:  begin r = ua * ub;           return r[63:32]; end
            OP_DIV: begin
                if (b == '0) return '1;
                if (a == 32'h8000_0000 && b == '1) return a;
                r = sa / sb; return r[31:0];
            end
            OP_DIVU:   return (b == '0) ? '1 : a / b;
            OP_REM: begin
                if (b == '0) return a;
                if (a == 32'h8000_0000 && b == '1) return '0;
                r = sa % sb; return r[31:0];
            end
            default:   return (b == '0) ? a : a % b;
        endcase
    endfunction

    // ---------------- behavioural MDU: done pulse XLEN+1 edges after start ----------------
    logic [5:0]      mdu_cnt;
    logic            mdu_done, spurious_ready;
    logic [XLEN-1:0] mdu_pend, mdu_junk;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mdu_cnt  <= '0;
            mdu_done <= 1'b0;
            mdu_pend <= '0;
            mdu_junk <= '0;
        end else begin
            mdu_done <= (mdu_cnt == 6'd1);
            mdu_junk <= $urandom;
            if (mdu_start) begin
                mdu_cnt  <= 6'(XLEN + 1);
                mdu_pend <= ref_mdu(mdu_control, mdu_operand_a, mdu_operand_b);
            end else if (mdu_cnt != 6'd0) begin
                mdu_cnt <= mdu_cnt - 6'd1;
            end
        end
    end
    assign mdu_ready  = mdu_done | spurious_ready;
    assign mdu_result = mdu_done ? mdu_pend : mdu_junk;

    // ---------------- scoreboard / arbitration model ----------------
    initial begin
        logic [XLEN:0] e, got;
        rr_m = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rr_m = 1'b0;
            end else begin
                if (!busy && req0_valid && !flush0 && req1_valid && !flush1) begin
                    n_checks++;
                    if ({req1_ready, req0_ready} !== (rr_m ? 2'b10 : 2'b01)) begin
                        n_fail++;
                        $display("FAIL rr_grant: ready{1,0} got %b expected %b", {req1_ready, req0_ready}, (rr_m ? 2'b10 : 2'b01));
                    end
                end
                if (req0_valid && req0_ready) begin
                    exp_q.push_back({1'b0, ref_mdu(req0_op, req0_a, req0_b)});
                    rr_m = 1'b1;
                end else if (req1_valid && req1_ready) begin
                    exp_q.push_back({1'b1, ref_mdu(req1_op, req1_a, req1_b)});
                    rr_m = 1'b0;
                end
                if (rsp0_valid || rsp1_valid) begin
                    n_checks++;
                    if (rsp0_valid && rsp1_valid) begin
                        n_fail++;
                        $display("FAIL rsp_exclusive: got both valid expected one");
                    end
                end
                if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                    n_checks++;
                    got = {rsp1_valid, rsp_result};
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL rsp_unexpected: got owner/result %h expected none", got);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) begin
                            n_fail++;
                            $display("FAIL rsp_data: got owner/result %h expected %h", got, e);
                        end
                    end
                    n_delivered++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        flush0 = 1'b0; flush1 = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        spurious_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic drive_req(input bit n, input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        if (n) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
        else   begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    endtask

    task automatic drop_req(input bit n);
        if (n) req1_valid = 1'b0;
        else   req0_valid = 1'b0;
    endtask

    task automatic wait_accept(input bit n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((n ? req1_ready : req0_ready) === 1'b1) begin
                @(posedge clk);
                #1 drop_req(n);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_rsp(input bit n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if ((n ? rsp1_valid : rsp0_valid) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic consume(input bit n);
        if (n) rsp1_ready = 1'b1;
        else   rsp0_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        #1;
        n_checks++;
        if ({busy, mdu_start, rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000", {busy, mdu_start, rsp0_valid, rsp1_valid, req0_ready, req1_ready});
        end
        n_checks++;
        if ({mdu_operand_a, mdu_operand_b, mdu_control, rsp_result} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got a=%h b=%h ctl=%h res=%h expected zeros", mdu_operand_a, mdu_operand_b, mdu_control, rsp_result);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if ({busy, req0_ready, req1_ready} !== 3'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b expected 000", {busy, req0_ready, req1_ready});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int starts, first;
        bit saw1;
        drive_req(1'b0, OP_MUL, 32'd7, 32'hFFFF_FFFD);
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL single_ready: got r0,r1=%b expected 10", {req0_ready, req1_ready});
        end
        @(posedge clk);
        #1 drop_req(1'b0);
        n_checks++;
        if ({mdu_start, busy, mdu_operand_a, mdu_operand_b, mdu_control} !== {1'b1, 1'b1, 32'd7, 32'hFFFF_FFFD, OP_MUL}) begin
            n_fail++;
            $display("FAIL single_issue: got start=%b a=%h b=%h ctl=%h expected 1 7 fffffffd 0", mdu_start, mdu_operand_a, mdu_operand_b, mdu_control);
        end
        starts = 1; first = -1; saw1 = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (mdu_start) starts++;
            if (rsp1_valid) saw1 = 1'b1;
            if (rsp0_valid) begin
                first = k;
                break;
            end
        end
        n_checks++;
        if (starts != 1) begin n_fail++; $display("FAIL single_starts: got %0d expected 1", starts); end
        n_checks++;
        if (first != XLEN + 3) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", first, XLEN + 3); end
        n_checks++;
        if (rsp_result !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL single_result: got %h expected ffffffeb", rsp_result); end
        n_checks++;
        if (saw1) begin n_fail++; $display("FAIL single_rsp1: got 1 expected 0"); end
        consume(1'b0);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy %b expected 0", busy); end
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        drive_req(1'b0, OP_DIVU, 32'd100, 32'd7);
        drive_req(1'b1, OP_REMU, 32'd100, 32'd7);
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL rr_first: got r0,r1=%b expected 10", {req0_ready, req1_ready});
        end
        wait_accept(1'b0, 4, ok);
        wait_rsp(1'b0, 60, ok);
        n_checks++;
        if (!ok || rsp_result !== 32'd14) begin n_fail++; $display("FAIL rr_divu: got ok=%b res=%0d expected 1 14", ok, rsp_result); end
        consume(1'b0);
        wait_accept(1'b1, 4, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rr_second_accept: got 0 expected 1"); end
        wait_rsp(1'b1, 60, ok);
        n_checks++;
        if (!ok || rsp_result !== 32'd2) begin n_fail++; $display("FAIL rr_remu: got ok=%b res=%0d expected 1 2", ok, rsp_result); end
        consume(1'b1);
        // A lone req0 grant hands priority to req1 for the next contested pair.
        drive_req(1'b0, OP_MUL, 32'd3, 32'd5);
        wait_accept(1'b0, 4, ok);
        wait_rsp(1'b0, 60, ok);
        consume(1'b0);
        drive_req(1'b0, OP_MULH, $urandom, $urandom);
        drive_req(1'b1, OP_MULHSU, $urandom, $urandom);
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL rr_alternate: got r0,r1=%b expected 01", {req0_ready, req1_ready});
        end
        wait_accept(1'b1, 4, ok);
        wait_rsp(1'b1, 60, ok);
        consume(1'b1);
        wait_accept(1'b0, 4, ok);
        wait_rsp(1'b0, 60, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rr_pair2_done: got 0 expected 1"); end
        consume(1'b0);
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [XLEN-1:0] a, b, exp;
        logic [1:0] st;
        a = $urandom; b = $urandom | 32'd1;
        exp = ref_mdu(OP_REM, a, b);
        drive_req(1'b1, OP_REM, a, b);
        wait_accept(1'b1, 4, ok);
        wait_rsp(1'b1, 60, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL bp_rsp: got timeout expected rsp1_valid"); end
        drive_req(1'b0, OP_MUL, $urandom, $urandom);
        #1;
        st = state_dbg;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({rsp1_valid, busy, req0_ready, rsp_result, state_dbg} !== {1'b1, 1'b1, 1'b0, exp, st}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b busy=%b r0rdy=%b res=%h st=%0d expected 1 1 0 %h %0d",
                         i, rsp1_valid, busy, req0_ready, rsp_result, state_dbg, exp, st);
            end
            @(posedge clk);
            #1;
        end
        consume(1'b1);
        wait_accept(1'b0, 4, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL bp_next_accept: got 0 expected 1"); end
        wait_rsp(1'b0, 60, ok);
        consume(1'b0);
    endtask

    task automatic test_flush_wait();
        bit ok, got, saw0;
        drive_req(1'b0, OP_DIV, $urandom, $urandom | 32'd1);
        wait_accept(1'b0, 4, ok);
        drive_req(1'b1, OP_MULHU, $urandom, $urandom);
        repeat (5) @(posedge clk);
        #1 flush0 = 1'b1;
        @(posedge clk);
        #1 flush0 = 1'b0;
        void'(exp_q.pop_front());
        got = 1'b0; saw0 = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp0_valid) saw0 = 1'b1;
            if (mdu_ready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL fw_mdu_done: got 0 expected 1"); end
        n_checks++;
        if ({busy, rsp0_valid, req1_ready, saw0} !== 4'b0010) begin
            n_fail++;
            $display("FAIL fw_idle: got busy,rsp0,r1rdy,saw0=%b expected 0010", {busy, rsp0_valid, req1_ready, saw0});
        end
        wait_accept(1'b1, 4, ok);
        wait_rsp(1'b1, 60, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL fw_req1_rsp: got timeout expected rsp1_valid"); end
        consume(1'b1);
    endtask

    task automatic test_flush_resp();
        bit ok;
        drive_req(1'b0, OP_MULH, $urandom, $urandom);
        wait_accept(1'b0, 4, ok);
        wait_rsp(1'b0, 60, ok);
        flush0 = 1'b1;
        drive_req(1'b1, OP_MUL, $urandom | 32'd1, $urandom | 32'd1);
        flush1 = 1'b1;
        #1;
        n_checks++;
        if ({ok, rsp0_valid} !== 2'b10) begin n_fail++; $display("FAIL fr_drop: got ok,rsp0=%b expected 10", {ok, rsp0_valid}); end
        void'(exp_q.pop_front());
        @(posedge clk);
        #1 flush0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({busy, req1_ready, rsp0_valid} !== 3'b000) begin
                n_fail++;
                $display("FAIL fr_flush1_hold[%0d]: got busy,r1rdy,rsp0=%b expected 000", i, {busy, req1_ready, rsp0_valid});
            end
            @(posedge clk);
            #1;
        end
        flush1 = 1'b0;
        wait_accept(1'b1, 4, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL fr_req1_accept: got 0 expected 1"); end
        wait_rsp(1'b1, 60, ok);
        consume(1'b1);
    endtask

    task automatic test_reset_wait();
        bit ok;
        logic [XLEN-1:0] a, b;
        drive_req(1'b0, OP_DIVU, $urandom | 32'd1, $urandom | 32'd1);
        wait_accept(1'b0, 4, ok);
        repeat (8) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, mdu_start, rsp0_valid, rsp1_valid, mdu_operand_a, mdu_operand_b, mdu_control, rsp_result} !== '0) begin
            n_fail++;
            $display("FAIL rw_async: got busy=%b start=%b a=%h b=%h ctl=%h res=%h expected zeros",
                     busy, mdu_start, mdu_operand_a, mdu_operand_b, mdu_control, rsp_result);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        spurious_ready = 1'b1;
        @(posedge clk);
        #1 spurious_ready = 1'b0;
        n_checks++;
        if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL rw_spurious: got busy,rsp0,rsp1=%b expected 000", {busy, rsp0_valid, rsp1_valid});
        end
        a = $urandom; b = $urandom;
        drive_req(1'b1, OP_MULHSU, a, b);
        wait_accept(1'b1, 4, ok);
        wait_rsp(1'b1, 60, ok);
        n_checks++;
        if (!ok || rsp_result !== ref_mdu(OP_MULHSU, a, b)) begin
            n_fail++;
            $display("FAIL rw_fresh: got ok=%b res=%h expected 1 %h", ok, rsp_result, ref_mdu(OP_MULHSU, a, b));
        end
        consume(1'b1);
    endtask

    task automatic rand_driver(input bit n, input int count);
        bit ok;
        logic [XLEN-1:0] a, b;
        for (int i = 0; i < count; i++) begin
            case ($urandom_range(0, 5))
                0:       begin a = $urandom;       b = '0;            end
                1:       begin a = 32'h8000_0000;  b = 32'hFFFF_FFFF; end
                default: begin a = $urandom;       b = $urandom;      end
            endcase
            drive_req(n, 3'($urandom_range(0, 7)), a, b);
            wait_accept(n, 300, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL rand_accept%0d[%0d]: got timeout expected grant", n, i);
                drop_req(n);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_responder(input int target);
        int guard;
        guard = 0;
        while (n_delivered < target && guard < 4000) begin
            @(posedge clk);
            #1;
            rsp0_ready = ($urandom_range(0, 2) != 0);
            rsp1_ready = ($urandom_range(0, 2) != 0);
            guard++;
        end
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    task automatic test_random();
        int c0, c1, target;
        c0 = $urandom_range(8, 14);
        c1 = $urandom_range(8, 14);
        target = n_delivered + c0 + c1;
        fork
            rand_driver(1'b0, c0);
            rand_driver(1'b1, c1);
            rand_responder(target);
        join
        n_checks++;
        if (n_delivered != target) begin
            n_fail++;
            $display("FAIL rand_delivered: got %0d expected %0d", n_delivered, target);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_leftover: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_flush_wait();
        test_flush_resp();
        test_reset_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
